// File: rtl/legv8_multicycle_ctrl.sv
// legv8_multicycle_ctrl: control sequencer for the multicycle LEGv8 datapath.
// Steps the shared memory, ALU and IR/A/B/ALUOut/MDR registers through
// fetch, decode, execute, memory and write-back. It stalls on MemReady,
// traps on unsupported opcodes and counts retired instructions.

module legv8_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      Op,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             Reg2Loc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUOutWrite,
    output logic             PCSrc,
    output logic             Done,
    output logic             Halted,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_PCINC  = 4'd10,
        ST_TRAP   = 4'd11
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              is_ldur;
    logic              is_stur;
    logic              is_cbz;
    logic              is_rtype;
    logic              uses_rt;
    logic [CNT_W-1:0]  retired_cnt;

    assign is_ldur  = (Op == 11'b11111000010);
    assign is_stur  = (Op == 11'b11111000000);
    assign is_cbz   = (Op[10:3] == 8'b10110100);
    assign is_rtype = Op[10] & ~Op[8] & (Op[6:4] == 3'b101) & (Op[2:0] == 3'b000);
    assign uses_rt  = is_stur | is_cbz;

    assign State   = state;
    assign Retired = retired_cnt;

    // State register; reset forces RESET immediately so memory strobes drop at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; PC+4 is ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=0.
    always_comb begin
        state_next  = state;
        Reg2Loc     = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        ALUOutWrite = 1'b0;
        PCSrc       = 1'b0;
        Done        = 1'b0;
        Halted      = 1'b0;
        case (state)
            ST_FETCH: begin
                MemRead = 1'b1;
                IRWrite = MemReady;
                if (MemReady) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                Reg2Loc     = uses_rt;
                ALUSrcB     = 2'b11;
                ALUOutWrite = 1'b1;
                if (is_ldur || is_stur) begin
                    state_next = ST_MEMADR;
                end else if (is_rtype) begin
                    state_next = ST_EXEC;
                end else if (is_cbz) begin
                    state_next = ST_BRANCH;
                end else begin
                    state_next = ST_TRAP;
                end
            end
            ST_MEMADR: begin
                Reg2Loc     = uses_rt;
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALUOutWrite = 1'b1;
                state_next  = is_ldur ? ST_MEMRD : ST_MEMWR;
            end
            ST_MEMRD: begin
                Reg2Loc = uses_rt;
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (MemReady) begin
                    state_next = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                Reg2Loc    = uses_rt;
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                ALUSrcB    = 2'b01;
                PCWrite    = 1'b1;
                Done       = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWR: begin
                Reg2Loc  = uses_rt;
                IorD     = 1'b1;
                MemWrite = 1'b1;
                ALUSrcB  = 2'b01;
                PCWrite  = MemReady;
                Done     = MemReady;
                if (MemReady) begin
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC: begin
                Reg2Loc     = uses_rt;
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b10;
                ALUOutWrite = 1'b1;
                state_next  = ST_ALUWB;
            end
            ST_ALUWB: begin
                Reg2Loc    = uses_rt;
                RegWrite   = 1'b1;
                ALUSrcB    = 2'b01;
                PCWrite    = 1'b1;
                Done       = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BRANCH: begin
                Reg2Loc = uses_rt;
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                if (Zero) begin
                    PCWrite    = 1'b1;
                    PCSrc      = 1'b1;
                    Done       = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_PCINC;
                end
            end
            ST_PCINC: begin
                Reg2Loc    = uses_rt;
                ALUSrcB    = 2'b01;
                PCWrite    = 1'b1;
                Done       = 1'b1;
                state_next = ST_FETCH;
            end
            ST_TRAP: begin
                Halted     = 1'b1;
                state_next = ST_TRAP;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    // Retired-instruction counter, bumped on every Done and wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_cnt <= '0;
        end else if (Done) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// tb_legv8_multicycle_ctrl: drives directed and random instruction streams
// into two controller instances (32-bit and 4-bit counters) and compares
// them every cycle against a path-based model of the sequencer.

module tb_legv8_multicycle_ctrl;

    localparam int C_R   = 0;
    localparam int C_LD  = 1;
    localparam int C_ST  = 2;
    localparam int C_CBZ = 3;
    localparam int C_BAD = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       reg2loc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       aluoutwrite;
        logic       pcsrc;
        logic       done;
        logic       halted;
    } out_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] op;
    logic        zero;
    logic        mem_ready;

    logic        reg2loc, srca, memtoreg, regwrite, memread, memwrite, iord;
    logic        irwrite, pcwrite, aluoutwrite, pcsrc, done, halted;
    logic [1:0]  srcb, aluop;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        reg2loc_w, srca_w, memtoreg_w, regwrite_w, memread_w, memwrite_w, iord_w;
    logic        irwrite_w, pcwrite_w, aluoutwrite_w, pcsrc_w, done_w, halted_w;
    logic [1:0]  srcb_w, aluop_w;
    logic [3:0]  state_w;
    logic [3:0]  retired_w;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = '0;

    always #5 clk = ~clk;

    legv8_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Op(op), .Zero(zero), .MemReady(mem_ready),
        .Reg2Loc(reg2loc), .ALUSrcA(srca), .ALUSrcB(srcb), .ALUOp(aluop),
        .MemtoReg(memtoreg), .RegWrite(regwrite), .MemRead(memread), .MemWrite(memwrite),
        .IorD(iord), .IRWrite(irwrite), .PCWrite(pcwrite), .ALUOutWrite(aluoutwrite),
        .PCSrc(pcsrc), .Done(done), .Halted(halted), .State(state), .Retired(retired)
    );

    legv8_multicycle_ctrl #(.CNT_W(4)) dut_w4 (
        .clk(clk), .reset(reset), .Op(op), .Zero(zero), .MemReady(mem_ready),
        .Reg2Loc(reg2loc_w), .ALUSrcA(srca_w), .ALUSrcB(srcb_w), .ALUOp(aluop_w),
        .MemtoReg(memtoreg_w), .RegWrite(regwrite_w), .MemRead(memread_w), .MemWrite(memwrite_w),
        .IorD(iord_w), .IRWrite(irwrite_w), .PCWrite(pcwrite_w), .ALUOutWrite(aluoutwrite_w),
        .PCSrc(pcsrc_w), .Done(done_w), .Halted(halted_w), .State(state_w), .Retired(retired_w)
    );

    // Required outputs for a given state code, straight from the state action table.
    function automatic out_t expect_out(input int code, input logic rt, input logic mr, input logic z);
        out_t o;
        o = '0;
        o.st = 4'(code);
        if (code >= 2 && code <= 10) o.reg2loc = rt;
        case (code)
            1: begin o.memread = 1'b1; o.irwrite = mr; end
            2: begin o.srcb = 2'b11; o.aluoutwrite = 1'b1; end
            3: begin o.srca = 1'b1; o.srcb = 2'b10; o.aluoutwrite = 1'b1; end
            4: begin o.iord = 1'b1; o.memread = 1'b1; end
            5: begin o.regwrite = 1'b1; o.memtoreg = 1'b1; o.srcb = 2'b01; o.pcwrite = 1'b1; o.done = 1'b1; end
            6: begin o.iord = 1'b1; o.memwrite = 1'b1; o.srcb = 2'b01; o.pcwrite = mr; o.done = mr; end
            7: begin o.srca = 1'b1; o.aluop = 2'b10; o.aluoutwrite = 1'b1; end
            8: begin o.regwrite = 1'b1; o.srcb = 2'b01; o.pcwrite = 1'b1; o.done = 1'b1; end
            9: begin
                o.srca = 1'b1; o.aluop = 2'b01;
                if (z) begin o.pcwrite = 1'b1; o.pcsrc = 1'b1; o.done = 1'b1; end
            end
            10: begin o.srcb = 2'b01; o.pcwrite = 1'b1; o.done = 1'b1; end
            11: o.halted = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] o, input logic mr, input logic z);
        op        = o;
        mem_ready = mr;
        zero      = z;
    endtask

    // Compares both instances against the model for the current cycle, then books any retirement.
    task automatic checkOutput(input out_t e);
        out_t a;
        out_t aw;
        a  = {state, reg2loc, srca, srcb, aluop, memtoreg, regwrite, memread, memwrite,
              iord, irwrite, pcwrite, aluoutwrite, pcsrc, done, halted};
        aw = {state_w, reg2loc_w, srca_w, srcb_w, aluop_w, memtoreg_w, regwrite_w, memread_w, memwrite_w,
              iord_w, irwrite_w, pcwrite_w, aluoutwrite_w, pcsrc_w, done_w, halted_w};
        checkVal("outputs", 32'(a), 32'(e));
        checkVal("outputs_w4", 32'(aw), 32'(e));
        checkVal("retired", retired, model_cnt);
        checkVal("retired_w4", 32'(retired_w), 32'(model_cnt[3:0]));
        if (e.done) model_cnt = model_cnt + 32'd1;
    endtask

    task automatic step(input logic [10:0] o, input logic mr, input logic z, input out_t e);
        applyStimulus(o, mr, z);
        #3;
        checkOutput(e);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset: outputs must clear immediately, then one RESET cycle precedes FETCH.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        checkVal("reset_state", 32'(state), 32'd0);
        checkVal("reset_memread", 32'(memread), 32'd0);
        checkVal("reset_memwrite", 32'(memwrite), 32'd0);
        checkVal("reset_retired", retired, 32'd0);
        checkVal("reset_retired_w4", 32'(retired_w), 32'd0);
        model_cnt = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(11'($urandom), 1'($urandom), 1'($urandom), expect_out(0, 1'b0, 1'b0, 1'b0));
        advance();
    endtask

    // Builds the state path of one instruction from its class and wait counts, then walks it.
    task automatic run_instr(input logic [10:0] o, input int cls, input logic z,
                             input int wf, input int wm, input bit abort_memwr);
        int   path[$];
        logic mrs[$];
        logic rt;
        logic mr;
        logic zz;
        rt = (cls == C_ST) || (cls == C_CBZ);
        for (int i = 0; i < wf; i++) begin path.push_back(1); mrs.push_back(1'b0); end
        path.push_back(1); mrs.push_back(1'b1);
        path.push_back(2); mrs.push_back(1'($urandom));
        case (cls)
            C_R: begin
                path.push_back(7); mrs.push_back(1'($urandom));
                path.push_back(8); mrs.push_back(1'($urandom));
            end
            C_LD: begin
                path.push_back(3); mrs.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin path.push_back(4); mrs.push_back(1'b0); end
                path.push_back(4); mrs.push_back(1'b1);
                path.push_back(5); mrs.push_back(1'($urandom));
            end
            C_ST: begin
                path.push_back(3); mrs.push_back(1'($urandom));
                for (int i = 0; i < wm; i++) begin path.push_back(6); mrs.push_back(1'b0); end
                path.push_back(6); mrs.push_back(1'b1);
            end
            C_CBZ: begin
                path.push_back(9); mrs.push_back(1'($urandom));
                if (!z) begin path.push_back(10); mrs.push_back(1'($urandom)); end
            end
            default: begin
                for (int i = 0; i < 11; i++) begin path.push_back(11); mrs.push_back(1'($urandom)); end
            end
        endcase
        for (int i = 0; i < path.size(); i++) begin
            mr = mrs[i];
            zz = (path[i] == 9) ? z : 1'($urandom);
            step((path[i] == 1) ? 11'($urandom) : o, mr, zz, expect_out(path[i], rt, mr, zz));
            if (abort_memwr && path[i] == 6 && !mr) begin
                do_reset();
                return;
            end
            advance();
        end
    endtask

    function automatic logic [10:0] rand_rtype();
        return {1'b1, 1'($urandom), 1'b0, 1'($urandom), 3'b101, 1'($urandom), 3'b000};
    endfunction

    initial begin
        int cls;
        reset     = 1'b0;
        op        = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        #1;
        do_reset();

        run_instr(11'b10001011000, C_R, 1'b0, 0, 0, 1'b0);
        checkVal("add_retired", retired, 32'd1);
        checkVal("add_back_to_fetch", 32'(state), 32'd1);

        run_instr(11'b11111000010, C_LD, 1'b0, 0, 2, 1'b0);
        checkVal("ldur_retired", retired, 32'd2);
        checkVal("ldur_back_to_fetch", 32'(state), 32'd1);

        run_instr(11'b11111000000, C_ST, 1'b0, 1, 1, 1'b0);
        run_instr(11'b10110100101, C_CBZ, 1'b1, 0, 0, 1'b0);
        run_instr(11'b10110100101, C_CBZ, 1'b0, 0, 0, 1'b0);
        checkVal("cbz_retired", retired, 32'd5);

        run_instr(11'b11111111111, C_BAD, 1'b0, 0, 0, 1'b0);
        checkVal("trap_halted", 32'(halted), 32'd1);
        checkVal("trap_retired", retired, 32'd5);
        do_reset();

        run_instr(11'b10001011000, C_R, 1'b0, 0, 0, 1'b0);
        run_instr(11'b11111000000, C_ST, 1'b0, 0, 3, 1'b1);
        checkVal("abort_fetch_resumes", 32'(state), 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_instr(11'b10001011000, C_R, 1'b0, 0, 0, 1'b0);
        end
        checkVal("wrap_retired_w4", 32'(retired_w), 32'd0);
        checkVal("wrap_retired_32", retired, 32'd16);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            cls = int'($urandom_range(0, 3));
            case (cls)
                C_R:  run_instr(rand_rtype(), C_R, 1'b0, int'($urandom_range(0, 2)), 0, 1'b0);
                C_LD: run_instr(11'b11111000010, C_LD, 1'b0, int'($urandom_range(0, 2)),
                                int'($urandom_range(0, 3)), 1'b0);
                C_ST: run_instr(11'b11111000000, C_ST, 1'b0, int'($urandom_range(0, 2)),
                                int'($urandom_range(0, 3)), 1'b0);
                default: run_instr({8'b10110100, 3'($urandom)}, C_CBZ, 1'($urandom),
                                   int'($urandom_range(0, 2)), 0, 1'b0);
            endcase
        end
        run_instr(11'b00000000000, C_BAD, 1'b0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
